// File: rtl/udma_ch_pkg.sv
// Shared types and helpers for the uDMA RX channel engine.
// Holds the datasize/state enums and the beat-size helper.
package udma_ch_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } datasize_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    // Encodings 10 and 11 both mean a 4-byte word.
    function automatic logic [2:0] beat_bytes(input logic [1:0] ds);
        logic [2:0] n;
        case (ds)
            BYTE:    n = 3'd1;
            HALF:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/udma_ch_lane_steer.sv
// Byte-lane steering for one stream beat into a 32-bit L2 word.
// Ports: datasize_i, addr_lsb_i, data_i in; wdata_o, be_o out.
module udma_ch_lane_steer
    import udma_ch_pkg::*;
(
    input  logic [1:0]  datasize_i,
    input  logic [1:0]  addr_lsb_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o
);

    always_comb begin
        wdata_o = data_i;
        be_o    = 4'hF;
        case (datasize_i)
            BYTE: begin
                be_o    = 4'b0001 << addr_lsb_i;
                wdata_o = {24'd0, data_i[7:0]} << {addr_lsb_i, 3'b000};
            end
            HALF: begin
                // Odd byte offset is ignored: halves land on lane 0 or 2.
                be_o    = addr_lsb_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = addr_lsb_i[1] ? {data_i[15:0], 16'd0}
                                        : {16'd0, data_i[15:0]};
            end
            default: begin
                be_o    = 4'hF;
                wdata_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/udma_rx_ch_engine.sv
// uDMA RX channel: turns a peripheral byte/half/word stream into aligned
// L2 writes. Ports: cfg_* (setup/status), data_* (stream), l2_* (req/gnt), end_event_o.
module udma_rx_ch_engine
    import udma_ch_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rstn_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_size_i,
    input  logic                      cfg_continuous_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    output logic                      cfg_en_o,
    output logic                      cfg_pending_o,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
    output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
    input  logic [1:0]                data_datasize_i,
    input  logic [31:0]               data_i,
    input  logic                      data_valid_i,
    output logic                      data_ready_o,
    output logic                      l2_req_o,
    input  logic                      l2_gnt_i,
    output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
    output logic [31:0]               l2_wdata_o,
    output logic [3:0]                l2_be_o,
    output logic                      end_event_o
);

    localparam int AW = L2_AWIDTH_NOAL;
    localparam int TS = TRANS_SIZE;

    ch_state_e       state_q, state_d;
    logic [AW-1:0]   addr_q, org_addr_q, sh_addr_q, waddr_q;
    logic [TS-1:0]   left_q, org_size_q, sh_size_q;
    logic            pend_q, req_q, last_q, end_q;
    logic [31:0]     wdata_q, steer_wdata;
    logic [3:0]      be_q, steer_be;

    logic [2:0]      bb;
    logic            en_ok, accept, is_last, stopping, gnt_fire;

    assign bb       = beat_bytes(data_datasize_i);
    assign en_ok    = cfg_en_i & (cfg_size_i != '0);
    assign accept   = data_valid_i & data_ready_o;
    assign is_last  = left_q <= TS'(bb);
    // RUN with nothing left: last beat issued, waiting for its grant.
    assign stopping = (state_q == RUN) & (left_q == '0);
    assign gnt_fire = req_q & l2_gnt_i;

    udma_ch_lane_steer u_steer (
        .datasize_i (data_datasize_i),
        .addr_lsb_i (addr_q[1:0]),
        .data_i     (data_i),
        .wdata_o    (steer_wdata),
        .be_o       (steer_be)
    );

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en_ok & ~cfg_clr_i) state_d = RUN;
            RUN: begin
                if (cfg_clr_i)
                    state_d = IDLE;
                else if (stopping & ~pend_q & gnt_fire & ~en_ok)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_en_o     = (state_q == RUN);
        data_ready_o = (state_q == RUN) & (left_q != '0)
                     & (~req_q | l2_gnt_i) & ~cfg_clr_i;
    end

    // Address/size counters and the pending shadow.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            addr_q     <= '0;
            left_q     <= '0;
            org_addr_q <= '0;
            org_size_q <= '0;
            sh_addr_q  <= '0;
            sh_size_q  <= '0;
            pend_q     <= 1'b0;
        end else if (cfg_clr_i) begin
            addr_q <= '0;
            left_q <= '0;
            pend_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (en_ok) begin
                addr_q     <= cfg_startaddr_i;
                left_q     <= cfg_size_i;
                org_addr_q <= cfg_startaddr_i;
                org_size_q <= cfg_size_i;
            end
        end else begin
            if (accept) begin
                if (is_last & pend_q) begin
                    addr_q     <= sh_addr_q;
                    left_q     <= sh_size_q;
                    org_addr_q <= sh_addr_q;
                    org_size_q <= sh_size_q;
                    pend_q     <= 1'b0;
                end else if (is_last & cfg_continuous_i) begin
                    addr_q <= org_addr_q;
                    left_q <= org_size_q;
                end else begin
                    addr_q <= addr_q + AW'(bb);
                    left_q <= is_last ? '0 : left_q - TS'(bb);
                end
            end else if (stopping & pend_q) begin
                // Queued while the final beat was still in flight.
                addr_q     <= sh_addr_q;
                left_q     <= sh_size_q;
                org_addr_q <= sh_addr_q;
                org_size_q <= sh_size_q;
                pend_q     <= 1'b0;
            end
            // A new enable overrides any reload of the shadow above.
            if (en_ok) begin
                sh_addr_q <= cfg_startaddr_i;
                sh_size_q <= cfg_size_i;
                pend_q    <= 1'b1;
            end
        end
    end

    // Single output register toward L2, held until granted.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            req_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            last_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            if (accept) begin
                req_q   <= 1'b1;
                waddr_q <= {addr_q[AW-1:2], 2'b00};
                wdata_q <= steer_wdata;
                be_q    <= steer_be;
                last_q  <= is_last;
            end else if (gnt_fire) begin
                req_q  <= 1'b0;
                last_q <= 1'b0;
            end
            // An aborted buffer still drains its beat but raises no event.
            if (cfg_clr_i) last_q <= 1'b0;
            end_q <= gnt_fire & last_q & ~cfg_clr_i;
        end
    end

    assign cfg_pending_o    = pend_q;
    assign cfg_curr_addr_o  = addr_q;
    assign cfg_bytes_left_o = left_q;
    assign l2_req_o         = req_q;
    assign l2_addr_o        = waddr_q;
    assign l2_wdata_o       = wdata_q;
    assign l2_be_o          = be_q;
    assign end_event_o      = end_q;

endmodule
